// File: rtl/sound_player.sv
// Sound player: fetches samples from an external memory, attenuates them and emits them as PWM.
// Latency: one memory read per sample period; new sample_o appears 2 clocks into the period, pwm follows 1 clock later.
// Backpressure: none. The player paces itself with SAMPLE_DIV; start is ignored while busy, and stop aborts at once.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start, stop               - playback request / abort request (stop wins)
//   loop_en, len              - repeat flag and sample count, latched at an accepted start
//   vol                       - right-shift attenuation, latched at every sample capture
//   mem_rd_en, mem_addr       - sample memory read port (data returns one clock later)
//   mem_rdata                 - sample memory read data
//   sample_o, pwm             - attenuated current sample, registered PWM audio
//   busy, done                - not idle, one-clock completion pulse
module sound_player #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int PWM_W      = 8,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] len,
    input  logic [2:0]        vol,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] sample_o,
    output logic              pwm,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [ADDR_W-1:0] len_q,     len_d;
    logic              loop_q,    loop_d;
    logic [2:0]        vol_q,     vol_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [DATA_W-1:0] raw_q,     raw_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic              pwm_q,     pwm_d;
    logic              done_q,    done_d;

    logic              busy_w;

    assign busy_w    = (state_q != S_IDLE);
    // The raw word and its shift are stored separately; the attenuated value is formed on the way out.
    assign sample_o  = raw_q >> vol_q;
    assign mem_rd_en = (state_q == S_FETCH);
    assign mem_addr  = addr_q;
    assign busy      = busy_w;
    assign done      = done_q;
    assign pwm       = pwm_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        loop_d    = loop_q;
        vol_d     = vol_q;
        raw_d     = raw_q;
        done_d    = 1'b0;
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        // The sample-period counter runs in every busy state so periods are exactly SAMPLE_DIV clocks.
        div_d     = div_q;
        if (busy_w) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (len != '0) begin
                        len_d   = len;
                        loop_d  = loop_en;
                        addr_d  = '0;
                        div_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                raw_d   = mem_rdata;
                vol_d   = vol;
                state_d = S_HOLD;
            end
            default: begin // S_HOLD
                if (div_q == DIV_LAST) begin
                    if (addr_q != len_q - ADDR_W'(1)) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end else if (loop_q) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        raw_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        // Abort overrides everything, including a completion on the same clock.
        if (busy_w && stop) begin
            state_d = S_IDLE;
            raw_d   = '0;
            div_d   = '0;
            done_d  = 1'b0;
        end

        pwm_d = busy_w && (pwm_cnt_q < sample_o[DATA_W-1 -: PWM_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            vol_q     <= '0;
            div_q     <= '0;
            raw_q     <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            vol_q     <= vol_d;
            div_q     <= div_d;
            raw_q     <= raw_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_sound_player.sv
// Testbench for sound_player: directed scenarios plus randomized playbacks against a timeline model.
// Latency: model predicts every output per clock relative to the accepted start edge.
// Backpressure: not applicable; the bench drives start/stop/rst directly.
module tb_sound_player;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int PW = 4;
    localparam int SD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] len;
    logic [2:0]    vol;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] sample_o;
    logic          pwm;
    logic          busy;
    logic          done;

    sound_player #(.DATA_W(DW), .ADDR_W(AW), .PWM_W(PW), .SAMPLE_DIV(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .len(len), .vol(vol), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .sample_o(sample_o), .pwm(pwm), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Sample memory: data valid one clock after the address is presented.
    logic [DW-1:0] mem [16];
    always @(posedge clk) mem_rdata <= mem[mem_addr[3:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Timeline model of one playback. Index i counts clocks since the accepted start edge;
    // the player is busy from i=0 until 8*len (one-shot) or the stop index, whichever is first.
    int m_len, m_vol, m_stop, e0, r_base;
    bit m_loop;

    function automatic bit f_ended(input int i);
        if (m_stop >= 0 && i >= m_stop) return 1'b1;
        if (m_len == 0) return 1'b1;
        if (!m_loop && i >= SD * m_len) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit f_busy(input int i);
        return (i >= 0) && !f_ended(i);
    endfunction

    function automatic bit f_done(input int i);
        if (m_stop >= 0 && m_stop <= i) return 1'b0;
        return (m_len == 0 || !m_loop) && (i == SD * m_len);
    endfunction

    // Sample k is visible from 2 clocks into its period until 2 clocks into the next one.
    function automatic int f_sample(input int i);
        int k;
        if (!f_busy(i) || i < 2) return 0;
        k = (i - 2) / SD;
        return int'(mem[k % m_len]) >> m_vol;
    endfunction

    // PWM counter has been free-running since the last reset edge; pwm is the registered compare.
    function automatic bit f_pwm(input int i);
        int cnt;
        if (!f_busy(i - 1)) return 1'b0;
        cnt = (e0 + i - 1 - r_base) % (1 << PW);
        return cnt < (f_sample(i - 1) >> (DW - PW));
    endfunction

    task automatic run_play(input int l, input bit lp, input int v, input int s,
                            input bit glitch, output int hi);
        int endi;
        m_len = l; m_loop = lp; m_vol = v; m_stop = s; hi = 0;
        endi = (s >= 0) ? s : SD * l;
        len = AW'(l); loop_en = lp; vol = 3'(v); start = 1'b1; stop = 1'b0;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
        for (int i = 0; i < endi + 4; i++) begin
            chk("busy", 32'(busy), 32'(f_busy(i)));
            chk("done", 32'(done), 32'(f_done(i)));
            chk("rd_en", 32'(mem_rd_en), 32'(f_busy(i) && (i % SD == 0)));
            if (f_busy(i) && (i % SD == 0))
                chk("addr", 32'(mem_addr), 32'((i / SD) % l));
            chk("sample", 32'(sample_o), 32'(f_sample(i)));
            chk("pwm", 32'(pwm), 32'(f_pwm(i)));
            if (i >= 16 && i < 32 && pwm) hi++;
            start = (glitch && (i + 1 < endi)) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop  = (s >= 0 && i + 1 == s);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic load_ref_mem;
        for (int j = 0; j < 16; j++) mem[j] = 16'h0;
        mem[0] = 16'h0000;
        mem[1] = 16'h8000;
        mem[2] = 16'hFFFF;
    endtask

    initial begin
        int hi, l, s;
        bit lp;
        load_ref_mem();
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; len = '0; vol = '0;
        repeat (4) @(negedge clk);
        r_base = cyc;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd", 32'(mem_rd_en), 32'd0);
        chk("rst_sample", 32'(sample_o), 32'd0);
        chk("rst_pwm", 32'(pwm), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // One-shot over the reference memory, then with a start pulsed while busy.
        run_play(3, 1'b0, 0, -1, 1'b0, hi);
        run_play(3, 1'b0, 0, -1, 1'b1, hi);
        // Attenuated by one bit: last sample becomes 0x7FFF.
        run_play(3, 1'b0, 1, -1, 1'b0, hi);
        // Looping two samples, stopped mid-HOLD of the fourth period.
        run_play(2, 1'b1, 0, 3 * SD + 5, 1'b0, hi);
        // Zero length: immediate done, no reads.
        run_play(0, 1'b0, 0, -1, 1'b0, hi);

        // Duty cycle on a constant full-scale sample.
        mem[0] = 16'hFFFF;
        run_play(1, 1'b1, 0, 40, 1'b0, hi);
        chk("duty_full", 32'(hi), 32'd15);
        run_play(1, 1'b1, 1, 40, 1'b0, hi);
        chk("duty_vol1", 32'(hi), 32'd7);
        load_ref_mem();

        // start and stop together in IDLE: nothing starts.
        len = 16'd3; loop_en = 1'b0; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ss_busy", 32'(busy), 32'd0);
            chk("ss_done", 32'(done), 32'd0);
            chk("ss_rd", 32'(mem_rd_en), 32'd0);
            @(negedge clk);
        end

        // Reset during HOLD of a looping playback.
        mem[0] = 16'hFFFF;
        len = 16'd2; loop_en = 1'b1; vol = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_sample", 32'(sample_o), 32'hFFFF);
        rst = 1'b1;
        @(negedge clk);
        r_base = cyc;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_rd", 32'(mem_rd_en), 32'd0);
        chk("mrst_sample", 32'(sample_o), 32'd0);
        chk("mrst_pwm", 32'(pwm), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Randomized playbacks over random memory contents.
        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < 16; j++) mem[j] = 16'($urandom);
            l  = $urandom_range(1, 5);
            lp = 1'($urandom_range(0, 1));
            if (lp)
                s = $urandom_range(1, SD * (l + 2));
            else if ($urandom_range(0, 1) == 1)
                s = $urandom_range(1, SD * l - 1);
            else
                s = -1;
            run_play(l, lp, int'($urandom_range(0, 7)), s, 1'($urandom_range(0, 1)), hi);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
